management_register_interface: RTL and testbench

MANAGEMENT_REGISTER_INTERFACE -- requirements
Module: management_register_interface

---
 rtl/management_register_interface_if.sv | 27 ++
 rtl/management_register_interface.sv | 129 ++++++++++++
 tb/tb_management_register_interface.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/management_register_interface_if.sv
// management_register_interface_if: bridge-side register access plus external byte bus.
// slave is the register block's view; master is the bridge/bus-agent view.
interface management_register_interface_if;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [31:0] ctrl;
    logic [31:0] status;
    logic        bus_rd_en;
    logic        bus_wr_en;
    logic [14:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rvalid;
    logic [7:0]  bus_rdata;
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, status, bus_rvalid, bus_rdata,
        output rd_valid, rd_data, ctrl, bus_rd_en, bus_wr_en, bus_addr, bus_wdata
    );
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, status, bus_rvalid, bus_rdata,
        input  rd_valid, rd_data, ctrl, bus_rd_en, bus_wr_en, bus_addr, bus_wdata
    );
endinterface

// File: rtl/management_register_interface.sv
// management_register_interface: byte-wide local register file (ID/SCRATCH/CTRL/STATUS/ERR)
// with a single-outstanding external read path and posted external writes.
module management_register_interface #(
    parameter logic [31:0] FPGA_ID = 32'h0000_0000,
    parameter int          TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    management_register_interface_if.slave m
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXT_RD = 1'b1;
    logic [0:0]  state;
    logic [7:0]  cnt;
    logic        rd_pend;
    logic [14:0] raddr;
    logic [31:0] scratch, ctrl_r;
    logic [23:0] sh_scratch, sh_ctrl, stat_lat;
    logic [2:0]  err;
    logic        rd_valid_r, bus_rd_en_r, bus_wr_en_r;
    logic [7:0]  rd_data_r, bus_wdata_r;
    logic [14:0] bus_addr_r;
    logic        busy, rd_loc, wr_loc, rd_ok, wr_ok, ext_rd, ext_wr;
    logic        wr_scr, wr_ctl, err_rd, stat_rd, timeout;
    logic [5:0]  rd_word, wr_word;
    logic [1:0]  wr_lane;
    logic [31:0] scratch_nx, ctrl_nx, word;
    logic [7:0]  rd_byte;
    logic [2:0]  new_err;
    logic        unused;
    assign unused = ^{m.rd_addr[15], m.wr_addr[15]};
    always_comb begin
        busy       = state == EXT_RD;
        rd_loc     = m.rd_addr[14:8] == 7'd0;
        wr_loc     = m.wr_addr[14:8] == 7'd0;
        rd_ok      = m.rd_en & ~busy;
        wr_ok      = m.wr_en & ~busy;
        ext_rd     = rd_ok & ~rd_loc;
        ext_wr     = wr_ok & ~wr_loc;
        rd_word    = m.rd_addr[7:2];
        wr_word    = m.wr_addr[7:2];
        wr_lane    = m.wr_addr[1:0];
        wr_scr     = wr_ok & wr_loc & wr_word == 6'd1;
        wr_ctl     = wr_ok & wr_loc & wr_word == 6'd2;
        // write-then-read ordering: same-cycle reads see the committed word
        scratch_nx = (wr_scr & wr_lane == 2'd3) ? {m.wr_data, sh_scratch} : scratch;
        ctrl_nx    = (wr_ctl & wr_lane == 2'd3) ? {m.wr_data, sh_ctrl} : ctrl_r;
        word       = rd_word == 6'd0 ? FPGA_ID :
                     rd_word == 6'd1 ? scratch_nx :
                     rd_word == 6'd2 ? ctrl_nx :
                     rd_word == 6'd3 ? {stat_lat, m.status[7:0]} :
                     rd_word == 6'd4 ? {29'd0, err} : 32'd0;
        rd_byte    = word[{m.rd_addr[1:0], 3'b000} +: 8];
        err_rd     = rd_ok & rd_loc & rd_word == 6'd4;
        stat_rd    = rd_ok & rd_loc & rd_word == 6'd3 & m.rd_addr[1:0] == 2'd0;
        timeout    = busy & ~rd_pend & ~m.bus_rvalid & cnt == 8'(TIMEOUT - 1);
        new_err    = {m.wr_en & busy, m.rd_en & busy, timeout};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_pend     <= 1'b0;
            raddr       <= '0;
            scratch     <= '0;
            ctrl_r      <= '0;
            sh_scratch  <= '0;
            sh_ctrl     <= '0;
            stat_lat    <= '0;
            err         <= '0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= '0;
            bus_rd_en_r <= 1'b0;
            bus_wr_en_r <= 1'b0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
        end else begin
            scratch     <= scratch_nx;
            ctrl_r      <= ctrl_nx;
            if (wr_scr & wr_lane != 2'd3) sh_scratch[{wr_lane, 3'b000} +: 8] <= m.wr_data;
            if (wr_ctl & wr_lane != 2'd3) sh_ctrl[{wr_lane, 3'b000} +: 8] <= m.wr_data;
            if (stat_rd) stat_lat <= m.status[31:8];
            err         <= (err_rd ? 3'd0 : err) | new_err;
            rd_valid_r  <= 1'b0;
            bus_rd_en_r <= 1'b0;
            bus_wr_en_r <= 1'b0;
            if (rd_ok & rd_loc) begin
                rd_valid_r <= 1'b1;
                rd_data_r  <= rd_byte;
            end
            if (ext_wr) begin
                bus_wr_en_r <= 1'b1;
                bus_addr_r  <= m.wr_addr[14:0];
                bus_wdata_r <= m.wr_data;
            end
            // a colliding external write owns the bus first; the read request follows
            if (ext_rd) begin
                state   <= EXT_RD;
                raddr   <= m.rd_addr[14:0];
                cnt     <= '0;
                rd_pend <= ext_wr;
                if (!ext_wr) begin
                    bus_rd_en_r <= 1'b1;
                    bus_addr_r  <= m.rd_addr[14:0];
                end
            end
            if (busy) begin
                if (rd_pend) begin
                    rd_pend     <= 1'b0;
                    bus_rd_en_r <= 1'b1;
                    bus_addr_r  <= raddr;
                end else if (m.bus_rvalid | timeout) begin
                    state      <= IDLE;
                    rd_valid_r <= 1'b1;
                    rd_data_r  <= m.bus_rvalid ? m.bus_rdata : 8'hEE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
    assign m.rd_valid  = rd_valid_r;
    assign m.rd_data   = rd_data_r;
    assign m.ctrl      = ctrl_r;
    assign m.bus_rd_en = bus_rd_en_r;
    assign m.bus_wr_en = bus_wr_en_r;
    assign m.bus_addr  = bus_addr_r;
    assign m.bus_wdata = bus_wdata_r;
endmodule

// File: tb/tb_management_register_interface.sv
// tb_management_register_interface: scenario tasks plus randomized local traffic
// checked against a word/shadow-level model of the register map.
module tb_management_register_interface;
    localparam logic [31:0] ID = 32'hCAFE_BABE;
    localparam int TO = 10;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    management_register_interface_if b();
    management_register_interface #(.FPGA_ID(ID), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .m(b));
    int errors = 0;
    int checks = 0;
    logic [31:0] m_word [0:2];
    logic [23:0] m_sh [0:2];
    logic [31:0] m_lat;
    logic [2:0]  m_err;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < 3; i++) begin
            m_word[i] = '0;
            m_sh[i] = '0;
        end
        m_lat = '0;
        m_err = '0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (a[7:2] == 6'd1 || a[7:2] == 6'd2) begin
            if (a[1:0] == 2'd3) m_word[a[7:2]] = {d, m_sh[a[7:2]]};
            else m_sh[a[7:2]][8*a[1:0] +: 8] = d;
        end
    endtask

    task automatic model_read(input logic [7:0] a, output logic [7:0] e);
        logic [31:0] w;
        case (a[7:2])
            6'd0: w = ID;
            6'd1: w = m_word[1];
            6'd2: w = m_word[2];
            6'd3: begin
                if (a[1:0] == 2'd0) m_lat = b.status;
                w = (a[1:0] == 2'd0) ? b.status : m_lat;
            end
            6'd4: begin
                w = {29'd0, m_err};
                m_err = '0;
            end
            default: w = '0;
        endcase
        e = 8'(w >> (8 * a[1:0]));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        b.wr_en = 1'b1;
        b.wr_addr = a;
        b.wr_data = d;
        tick();
        b.wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic v, output logic [7:0] d);
        b.rd_en = 1'b1;
        b.rd_addr = a;
        tick();
        b.rd_en = 1'b0;
        v = b.rd_valid;
        d = b.rd_data;
    endtask

    task automatic test_reset;
        b.rd_en = 0; b.wr_en = 0; b.bus_rvalid = 0; b.rd_addr = 0; b.wr_addr = 0;
        b.wr_data = 0; b.bus_rdata = 0; b.status = 32'h1234_5678;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if ({b.rd_valid, b.bus_rd_en, b.bus_wr_en} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {b.rd_valid, b.bus_rd_en, b.bus_wr_en}); end
        checks++; if (b.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", b.rd_data); end
        checks++; if (b.bus_addr !== 15'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0000", b.bus_addr); end
        checks++; if (b.bus_wdata !== 8'h00) begin errors++; $display("FAIL reset_bus_wdata: got %h want 00", b.bus_wdata); end
        checks++; if (b.ctrl !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 00000000", b.ctrl); end
        rst_n = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic test_ctrl_bytes;
        logic [7:0] bytes [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 3; i++) begin
            do_write(16'h0008 + 16'(i), bytes[i]);
            model_write(8'h08 + 8'(i), bytes[i]);
            checks++; if (b.ctrl !== 32'h0) begin errors++; $display("FAIL ctrl_early lane%0d: got %h want 00000000", i, b.ctrl); end
        end
        do_write(16'h000B, bytes[3]);
        model_write(8'h0B, bytes[3]);
        checks++; if (b.ctrl !== 32'h4433_2211) begin errors++; $display("FAIL ctrl_commit: got %h want 44332211", b.ctrl); end
    endtask

    task automatic test_id_reads;
        logic [7:0] exp_id [0:3] = '{8'hBE, 8'hBA, 8'hFE, 8'hCA};
        b.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b.rd_addr = 16'(i);
            tick();
            checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== exp_id[i]) begin errors++; $display("FAIL id_byte%0d: got v=%b %h want v=1 %h", i, b.rd_valid, b.rd_data, exp_id[i]); end
        end
        b.rd_en = 1'b0;
        tick();
        checks++; if (b.rd_valid !== 1'b0) begin errors++; $display("FAIL id_valid_drop: got %b want 0", b.rd_valid); end
    endtask

    task automatic test_ext_write;
        do_write(16'h9234, 8'hA5);
        checks++; if (b.bus_wr_en !== 1'b1 || b.bus_addr !== 15'h1234 || b.bus_wdata !== 8'hA5) begin errors++; $display("FAIL ext_write: got en=%b a=%h d=%h want en=1 a=1234 d=a5", b.bus_wr_en, b.bus_addr, b.bus_wdata); end
        tick();
        checks++; if (b.bus_wr_en !== 1'b0) begin errors++; $display("FAIL ext_write_pulse: got %b want 0", b.bus_wr_en); end
    endtask

    task automatic test_ext_read;
        logic v;
        logic [7:0] d, e;
        logic quiet = 1'b1;
        b.rd_en = 1'b1; b.rd_addr = 16'h0200;
        tick();
        b.rd_en = 1'b0;
        checks++; if (b.bus_rd_en !== 1'b1 || b.bus_addr !== 15'h0200) begin errors++; $display("FAIL ext_rd_req: got en=%b a=%h want en=1 a=0200", b.bus_rd_en, b.bus_addr); end
        repeat (3) begin
            tick();
            if (b.rd_valid !== 1'b0 || b.bus_rd_en !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL ext_rd_wait: got stray strobe want none"); end
        b.bus_rvalid = 1'b1; b.bus_rdata = 8'h5A;
        tick();
        b.bus_rvalid = 1'b0;
        checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== 8'h5A) begin errors++; $display("FAIL ext_rd_data: got v=%b %h want v=1 5a", b.rd_valid, b.rd_data); end
        model_read(8'h10, e);
        do_read(16'h0010, v, d);
        checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL ext_rd_err: got v=%b %h want v=1 %h", v, d, e); end
    endtask

    task automatic test_timeout;
        logic v;
        logic [7:0] d, e;
        int n = -1;
        b.rd_en = 1'b1; b.rd_addr = 16'h0200;
        tick();
        b.rd_en = 1'b0;
        for (int i = 1; i <= TO + 5; i++) begin
            tick();
            if (b.rd_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++; if (n != TO || b.rd_data !== 8'hEE) begin errors++; $display("FAIL timeout: got cyc=%0d %h want cyc=%0d ee", n, b.rd_data, TO); end
        m_err[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            model_read(8'h10, e);
            do_read(16'h0010, v, d);
            checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL timeout_err read%0d: got v=%b %h want v=1 %h", k, v, d, e); end
        end
        b.bus_rvalid = 1'b1; b.bus_rdata = 8'h77;
        tick();
        b.bus_rvalid = 1'b0;
        checks++; if (b.rd_valid !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got %b want 0", b.rd_valid); end
    endtask

    task automatic test_busy_drop;
        logic v;
        logic [7:0] d, e;
        b.rd_en = 1'b1; b.rd_addr = 16'h0300;
        tick();
        b.rd_en = 1'b0;
        do_write(16'h0400, 8'h12);
        checks++; if (b.bus_wr_en !== 1'b0) begin errors++; $display("FAIL busy_wr: got %b want 0", b.bus_wr_en); end
        do_read(16'h0008, v, d);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL busy_rd: got %b want 0", v); end
        do_write(16'h000B, 8'hFF);
        checks++; if (b.ctrl !== m_word[2]) begin errors++; $display("FAIL busy_local_wr: got %h want %h", b.ctrl, m_word[2]); end
        b.bus_rvalid = 1'b1; b.bus_rdata = 8'h3C;
        tick();
        b.bus_rvalid = 1'b0;
        checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== 8'h3C) begin errors++; $display("FAIL busy_resp: got v=%b %h want v=1 3c", b.rd_valid, b.rd_data); end
        m_err = m_err | 3'b110;
        for (int k = 0; k < 2; k++) begin
            model_read(8'h10, e);
            do_read(16'h0010, v, d);
            checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL busy_err read%0d: got v=%b %h want v=1 %h", k, v, d, e); end
        end
    endtask

    task automatic test_simultaneous;
        logic v;
        logic [7:0] d, e, w;
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            do_write(16'h0004 + 16'(i), w);
            model_write(8'h04 + 8'(i), w);
        end
        w = 8'($urandom);
        b.rd_en = 1'b1; b.rd_addr = 16'h0007;
        b.wr_en = 1'b1; b.wr_addr = 16'h0007; b.wr_data = w;
        tick();
        b.rd_en = 1'b0; b.wr_en = 1'b0;
        model_write(8'h07, w);
        checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== w) begin errors++; $display("FAIL simul_local: got v=%b %h want v=1 %h", b.rd_valid, b.rd_data, w); end
        model_read(8'h04, e);
        do_read(16'h0004, v, d);
        checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL simul_lane0: got v=%b %h want v=1 %h", v, d, e); end
        b.rd_en = 1'b1; b.rd_addr = 16'h0500;
        b.wr_en = 1'b1; b.wr_addr = 16'h0600; b.wr_data = 8'h77;
        tick();
        b.rd_en = 1'b0; b.wr_en = 1'b0;
        checks++; if (b.bus_wr_en !== 1'b1 || b.bus_rd_en !== 1'b0 || b.bus_addr !== 15'h0600 || b.bus_wdata !== 8'h77) begin errors++; $display("FAIL simul_ext_wr: got wr=%b rd=%b a=%h d=%h want wr=1 rd=0 a=0600 d=77", b.bus_wr_en, b.bus_rd_en, b.bus_addr, b.bus_wdata); end
        tick();
        checks++; if (b.bus_rd_en !== 1'b1 || b.bus_wr_en !== 1'b0 || b.bus_addr !== 15'h0500) begin errors++; $display("FAIL simul_ext_rd: got rd=%b wr=%b a=%h want rd=1 wr=0 a=0500", b.bus_rd_en, b.bus_wr_en, b.bus_addr); end
        b.bus_rvalid = 1'b1; b.bus_rdata = 8'h99;
        tick();
        b.bus_rvalid = 1'b0;
        checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== 8'h99) begin errors++; $display("FAIL simul_ext_resp: got v=%b %h want v=1 99", b.rd_valid, b.rd_data); end
    endtask

    task automatic test_random_local;
        logic v;
        logic [7:0] a, d, e;
        for (int i = 0; i < 80; i++) begin
            a = 8'($urandom_range(0, 23));
            d = 8'($urandom);
            b.status = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write({1'($urandom_range(0, 1)), 7'd0, a}, d);
                model_write(a, d);
                checks++; if (b.ctrl !== m_word[2]) begin errors++; $display("FAIL rnd_ctrl it%0d: got %h want %h", i, b.ctrl, m_word[2]); end
            end else begin
                model_read(a, e);
                do_read({1'($urandom_range(0, 1)), 7'd0, a}, v, d);
                checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL rnd_read it%0d a=%h: got v=%b %h want v=1 %h", i, a, v, d, e); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic v;
        logic [7:0] d;
        logic quiet = 1'b1;
        do_write(16'h000B, 8'h5E);
        b.rd_en = 1'b1; b.rd_addr = 16'h0200;
        tick();
        b.rd_en = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        b.bus_rvalid = 1'b1; b.bus_rdata = 8'h55;
        tick();
        b.bus_rvalid = 1'b0;
        repeat (4) begin
            if (b.rd_valid !== 1'b0) quiet = 1'b0;
            tick();
        end
        checks++; if (!quiet) begin errors++; $display("FAIL reset_mid_valid: got rd_valid=1 want 0"); end
        checks++; if (b.ctrl !== 32'h0) begin errors++; $display("FAIL reset_mid_ctrl: got %h want 00000000", b.ctrl); end
        do_read(16'h0004, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL reset_mid_scratch: got v=%b %h want v=1 00", v, d); end
    endtask

    initial begin
        test_reset();
        test_ctrl_bytes();
        test_id_reads();
        test_ext_write();
        test_ext_read();
        test_timeout();
        test_busy_drop();
        test_simultaneous();
        test_random_local();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
